decode_queue_ctrl: RTL

Decode-to-issue instruction queue and stall controller. It sits after decode stage 2 and captures each muxed decoded-instruction bundle into a small FIFO. It presents the bundles in order to the issue stage over a valid/ready handshake. Because the fetch/decode front end has no ready input and keeps delivering instructions for a fixed number of cycles after a stall, the block raises a registered stall early enough to absorb those in-flight instructions.

---
 rtl/decode_queue_ctrl.sv | 87 ++++++++
 1 files changed

// File: rtl/decode_queue_ctrl.sv
// Decode-to-issue instruction queue with registered early stall.
// Captures decoded bundles into a small FIFO, presents them in order over
// valid/ready, and raises stall early enough to absorb the front end's
// in-flight instructions (skid) after it asserts.
module decode_queue_ctrl #(
  parameter int depth        = 4,
  parameter int ptrWidth     = 2,
  parameter int payloadWidth = 160,
  parameter int addressSize  = 64,
  parameter int skid         = 2
) (
  input  logic                    clock_i,
  input  logic                    resetn_i,
  input  logic                    enable_i,
  input  logic [payloadWidth-1:0] payload_i,
  input  logic [addressSize-1:0]  instructionAddress_i,
  input  logic                    flush_i,
  input  logic                    issueReady_i,
  output logic                    issueValid_o,
  output logic [payloadWidth-1:0] payload_o,
  output logic [addressSize-1:0]  instructionAddress_o,
  output logic                    stall_o,
  output logic [ptrWidth:0]       count_o,
  output logic                    overflow_o
);

  localparam logic [ptrWidth:0] DEPTH_C = (ptrWidth+1)'(depth);

  logic [payloadWidth-1:0] payload_mem [depth];
  logic [addressSize-1:0]  addr_mem    [depth];

  logic [ptrWidth-1:0] wr, rd;
  logic [ptrWidth:0]   count, next_count;
  logic                stall, overflow;
  logic                full, pop, push, drop, stall_next;

  assign full         = (count == DEPTH_C);
  assign issueValid_o = (count != '0);

  // Handshake decode: flush kills both sides; a full queue still accepts a
  // push when the head leaves in the same cycle.
  always_comb begin
    pop        = issueValid_o & issueReady_i & ~flush_i;
    push       = enable_i & ~flush_i & (~full | pop);
    drop       = enable_i & ~flush_i & full & ~pop;
    next_count = count + (ptrWidth+1)'(push) - (ptrWidth+1)'(pop);
    // Stall once the remaining free slots can only just hold the skid.
    stall_next = (int'(next_count) + skid) >= depth;
  end

  // Pointer, occupancy, stall and sticky overflow state.
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      wr       <= '0;
      rd       <= '0;
      count    <= '0;
      stall    <= 1'b0;
      overflow <= 1'b0;
    end else if (flush_i) begin
      wr       <= '0;
      rd       <= '0;
      count    <= '0;
      stall    <= 1'b0;
    end else begin
      if (push) wr <= wr + ptrWidth'(1);
      if (pop)  rd <= rd + ptrWidth'(1);
      count    <= next_count;
      stall    <= stall_next;
      overflow <= overflow | drop;
    end
  end

  // Entry storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clock_i) begin
    if (push) begin
      payload_mem[wr] <= payload_i;
      addr_mem[wr]    <= instructionAddress_i;
    end
  end

  assign payload_o            = payload_mem[rd];
  assign instructionAddress_o = addr_mem[rd];
  assign stall_o              = stall;
  assign count_o              = count;
  assign overflow_o           = overflow;

endmodule
